bp_me_stream_mem_responder: RTL and testbench

Memory-side responder for the BedRock stream memory interface. It accepts `mem_cmd` header and data beats from a cache engine (the I$ UCE or the FSM CCE), services them against an internal word-addressed memory array, and returns `mem_resp` header and data beats. It is the far end of the `mem_cmd_*`/`mem_resp_*` ports of the I$ test wrapper and replaces ad-hoc DRAM models in FE/ME unit benches.

---
 rtl/bp_me_stream_mem_responder_pkg.sv | 57 +++++
 rtl/bp_me_stream_mem_responder_beat_addr_gen.sv | 60 ++++++
 rtl/bp_me_stream_mem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_bp_me_stream_mem_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_stream_mem_responder_pkg.sv
// Shared types for the BedRock stream memory responder: header layout,
// message enums, responder FSM states and the wrapped beat-address helper.
package bp_me_stream_mem_responder_pkg;

    localparam int PADDR_W = 40;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1  = 3'd0,
        e_bedrock_msg_size_2  = 3'd1,
        e_bedrock_msg_size_4  = 3'd2,
        e_bedrock_msg_size_8  = 3'd3,
        e_bedrock_msg_size_16 = 3'd4,
        e_bedrock_msg_size_32 = 3'd5,
        e_bedrock_msg_size_64 = 3'd6
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        bp_bedrock_mem_type_e msg_type;
        logic [PADDR_W-1:0]   addr;
        bp_bedrock_msg_size_e size;
        logic [15:0]          payload;
    } bp_bedrock_mem_header_s;

    localparam int MEM_HEADER_W = $bits(bp_bedrock_mem_header_s);

    typedef enum logic [1:0] {
        e_ready    = 2'd0,
        e_cmd_data = 2'd1,
        e_wait     = 2'd2,
        e_resp     = 2'd3
    } state_e;

    // Byte address of beat k: offset wraps inside the size-aligned region,
    // which gives critical-word-first ordering.
    function automatic logic [PADDR_W-1:0] beat_byte_addr(
        input logic [PADDR_W-1:0] addr,
        input logic [2:0]         size,
        input logic [6:0]         beat,
        input logic [PADDR_W-1:0] beat_bytes
    );
        logic [PADDR_W-1:0] mask;
        logic [PADDR_W-1:0] offset;
        mask   = (PADDR_W'(1) << size) - PADDR_W'(1);
        offset = ((addr & mask) + PADDR_W'(beat) * beat_bytes) & mask;
        return (addr & ~mask) | offset;
    endfunction

endpackage

// File: rtl/bp_me_stream_mem_responder_beat_addr_gen.sv
// Beat counter plus wrap-address generator: gives the word index of the
// current and following beat and flags the final beat of the transfer.
module bp_me_stream_beat_addr_gen
    import bp_me_stream_mem_responder_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int mem_els_p    = 1024
)
(
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [PADDR_W-1:0]           i_addr,
    input  logic [2:0]                   i_size,
    input  logic                         i_clear,
    input  logic                         i_advance,
    output logic [$clog2(mem_els_p)-1:0] o_wordIdx,
    output logic [$clog2(mem_els_p)-1:0] o_nextWordIdx,
    output logic                         o_last
);

    localparam int BEAT_BYTES = data_width_p / 8;
    localparam int LG_B       = $clog2(BEAT_BYTES);
    localparam int IDX_W      = $clog2(mem_els_p);

    logic [6:0]         r_beat;
    logic [6:0]         w_nextBeat;
    logic [6:0]         w_beats;
    logic [PADDR_W-1:0] w_byteCur;
    logic [PADDR_W-1:0] w_byteNext;
    logic               w_unused;

    // Beat counter: restarts at the end of each phase, steps per accepted beat.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_beat <= '0;
        end else if (i_clear) begin
            r_beat <= '0;
        end else if (i_advance) begin
            r_beat <= w_nextBeat;
        end
    end

    // Number of beats: one for sub-beat sizes, otherwise size / beat width.
    always_comb begin
        w_beats = 7'd1;
        if (int'(i_size) >= LG_B) begin
            w_beats = 7'd1 << (int'(i_size) - LG_B);
        end
    end

    assign w_nextBeat    = r_beat + 7'd1;
    assign w_byteCur     = beat_byte_addr(i_addr, i_size, r_beat, PADDR_W'(BEAT_BYTES));
    assign w_byteNext    = beat_byte_addr(i_addr, i_size, w_nextBeat, PADDR_W'(BEAT_BYTES));
    assign o_wordIdx     = w_byteCur[LG_B +: IDX_W];
    assign o_nextWordIdx = w_byteNext[LG_B +: IDX_W];
    assign o_last        = (r_beat == (w_beats - 7'd1));
    assign w_unused      = ^{w_byteCur[PADDR_W-1:LG_B+IDX_W], w_byteCur[LG_B-1:0],
                             w_byteNext[PADDR_W-1:LG_B+IDX_W], w_byteNext[LG_B-1:0]};

endmodule

// File: rtl/bp_me_stream_mem_responder.sv
// Memory-side responder for the BedRock stream interface: absorbs a command,
// services it against a word array after a fixed latency, streams the reply.
module bp_me_stream_mem_responder
    import bp_me_stream_mem_responder_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int mem_els_p    = 1024,
    parameter int latency_p    = 4
)
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [MEM_HEADER_W-1:0] mem_cmd_header_i,
    input  logic [data_width_p-1:0] mem_cmd_data_i,
    input  logic                    mem_cmd_v_i,
    output logic                    mem_cmd_ready_and_o,
    input  logic                    mem_cmd_last_i,
    output logic [MEM_HEADER_W-1:0] mem_resp_header_o,
    output logic [data_width_p-1:0] mem_resp_data_o,
    output logic                    mem_resp_v_o,
    input  logic                    mem_resp_ready_and_i,
    output logic                    mem_resp_last_o
);

    localparam int BEAT_BYTES = data_width_p / 8;
    localparam int LG_B       = $clog2(BEAT_BYTES);
    localparam int IDX_W      = $clog2(mem_els_p);
    localparam int WAIT_W     = (latency_p > 1) ? $clog2(latency_p) : 1;

    bp_bedrock_mem_header_s w_cmdHdr;
    bp_bedrock_mem_header_s r_header;
    state_e                 r_state;
    logic                   r_cmdReady;
    logic                   r_respV;
    logic                   r_isRead;
    logic [WAIT_W-1:0]      r_waitCnt;
    logic [data_width_p-1:0] r_rdata;
    logic [data_width_p-1:0] r_mem [mem_els_p];

    logic [PADDR_W-1:0]     w_addr;
    logic [2:0]             w_size;
    bp_bedrock_mem_type_e   w_type;
    logic                   w_inIsRead;
    logic                   w_isWrite;
    logic                   w_cmdAccept;
    logic                   w_respFire;
    logic                   w_beatLast;
    logic                   w_respLast;
    logic                   w_expectLast;
    logic                   w_readEn;
    logic [IDX_W-1:0]       w_wordIdx;
    logic [IDX_W-1:0]       w_nextWordIdx;
    logic [IDX_W-1:0]       w_readIdx;
    logic [BEAT_BYTES-1:0]  w_wmask;
    logic [data_width_p-1:0] w_respData;

    assign w_cmdHdr = bp_bedrock_mem_header_s'(mem_cmd_header_i);

    // The live header drives addressing until it is captured on the first beat.
    assign w_addr     = (r_state == e_ready) ? w_cmdHdr.addr     : r_header.addr;
    assign w_size     = (r_state == e_ready) ? w_cmdHdr.size     : r_header.size;
    assign w_type     = (r_state == e_ready) ? w_cmdHdr.msg_type : r_header.msg_type;
    assign w_inIsRead = (w_cmdHdr.msg_type == e_bedrock_mem_rd) || (w_cmdHdr.msg_type == e_bedrock_mem_uc_rd);
    assign w_isWrite  = (w_type == e_bedrock_mem_wr) || (w_type == e_bedrock_mem_uc_wr);

    assign w_cmdAccept  = mem_cmd_v_i & r_cmdReady;
    assign w_respFire   = r_respV & mem_resp_ready_and_i;
    assign w_respLast   = r_isRead ? w_beatLast : 1'b1;
    assign w_expectLast = ((r_state == e_ready) && w_inIsRead) || w_beatLast;

    bp_me_stream_beat_addr_gen #(
        .data_width_p(data_width_p),
        .mem_els_p   (mem_els_p)
    ) beatGen (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .i_addr       (w_addr),
        .i_size       (w_size),
        .i_clear      ((w_cmdAccept & mem_cmd_last_i) | (w_respFire & w_respLast)),
        .i_advance    ((w_cmdAccept & ~mem_cmd_last_i) | (w_respFire & ~w_respLast)),
        .o_wordIdx    (w_wordIdx),
        .o_nextWordIdx(w_nextWordIdx),
        .o_last       (w_beatLast)
    );

    // Read one cycle ahead: beat 0 on the final wait cycle, beat k+1 as beat k drains.
    assign w_readEn  = r_isRead & (((r_state == e_wait) && (r_waitCnt == '0)) | (w_respFire & ~w_respLast));
    assign w_readIdx = (r_state == e_wait) ? w_wordIdx : w_nextWordIdx;

    // Byte lanes touched by a write: all for full beats, the addressed field otherwise.
    always_comb begin
        int off;
        int fieldBytes;
        w_wmask    = '0;
        off        = int'(w_addr[LG_B-1:0]);
        fieldBytes = 1 << int'(w_size);
        if (int'(w_size) >= LG_B) begin
            w_wmask = '1;
        end else begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
                if ((b >= off) && (b < off + fieldBytes)) begin
                    w_wmask[b] = 1'b1;
                end
            end
        end
    end

    // Array storage is never reset so contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (w_cmdAccept && w_isWrite) begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_wordIdx][b*8 +: 8] <= mem_cmd_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Synchronous read port; holds its word while the response is stalled.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rdata <= '0;
        end else if (w_readEn) begin
            r_rdata <= r_mem[w_readIdx];
        end
    end

    // Sub-beat reads replicate the addressed field across the whole beat.
    always_comb begin
        logic [data_width_p-1:0] shifted;
        int fieldBytes;
        int shiftBytes;
        int lane;
        w_respData = '0;
        fieldBytes = BEAT_BYTES;
        shiftBytes = 0;
        if (int'(r_header.size) < LG_B) begin
            fieldBytes = 1 << int'(r_header.size);
            shiftBytes = int'(r_header.addr[LG_B-1:0]);
        end
        shifted = r_rdata >> (8 * shiftBytes);
        for (int b = 0; b < BEAT_BYTES; b++) begin
            lane = b & (fieldBytes - 1);
            w_respData[b*8 +: 8] = shifted[lane*8 +: 8];
        end
    end

    // Transaction FSM: accept, count out the latency, then stream the response.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= e_ready;
            r_header   <= '0;
            r_cmdReady <= 1'b0;
            r_respV    <= 1'b0;
            r_isRead   <= 1'b0;
            r_waitCnt  <= '0;
        end else begin
            case (r_state)
                e_ready: begin
                    r_cmdReady <= 1'b1;
                    if (w_cmdAccept) begin
                        r_header <= w_cmdHdr;
                        r_isRead <= w_inIsRead;
                        if (mem_cmd_last_i) begin
                            r_state    <= e_wait;
                            r_waitCnt  <= WAIT_W'(latency_p - 1);
                            r_cmdReady <= 1'b0;
                        end else begin
                            r_state <= e_cmd_data;
                        end
                    end
                end
                e_cmd_data: begin
                    if (w_cmdAccept && mem_cmd_last_i) begin
                        r_state    <= e_wait;
                        r_waitCnt  <= WAIT_W'(latency_p - 1);
                        r_cmdReady <= 1'b0;
                    end
                end
                e_wait: begin
                    if (r_waitCnt == '0) begin
                        r_state <= e_resp;
                        r_respV <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt - WAIT_W'(1);
                    end
                end
                e_resp: begin
                    if (w_respFire && w_respLast) begin
                        r_state    <= e_ready;
                        r_respV    <= 1'b0;
                        r_cmdReady <= 1'b1;
                    end
                end
                default: r_state <= e_ready;
            endcase
        end
    end

    // Command last must line up with the expected beat count.
    assert property (@(posedge clk_i) disable iff (reset_i)
        w_cmdAccept |-> (mem_cmd_last_i == w_expectLast));

    assign mem_cmd_ready_and_o = r_cmdReady;
    assign mem_resp_v_o        = r_respV;
    assign mem_resp_last_o     = r_respV & w_respLast;
    assign mem_resp_header_o   = r_header;
    assign mem_resp_data_o     = (r_respV && r_isRead) ? w_respData : '0;

endmodule

// File: tb/tb_bp_me_stream_mem_responder.sv
// Scoreboard bench for the stream memory responder: stimulus pushes expected
// response beats, a negedge monitor compares every presented beat.
module tb_bp_me_stream_mem_responder;
    import bp_me_stream_mem_responder_pkg::*;

    typedef struct {
        bp_bedrock_mem_header_s hdr;
        logic [63:0]            data;
        logic                   last;
    } expBeat_t;

    logic                    clk;
    logic                    rst;
    bp_bedrock_mem_header_s  cmdHdr;
    logic [63:0]             cmdData;
    logic                    cmdV;
    logic                    cmdReady;
    logic                    cmdLast;
    logic [MEM_HEADER_W-1:0] respHdr;
    logic [63:0]             respData;
    logic                    respV;
    logic                    respReady;
    logic                    respLast;

    expBeat_t expQ[$];
    int compared   = 0;
    int mismatched = 0;
    int readyMode  = 0;

    bp_me_stream_mem_responder #(
        .data_width_p(64),
        .mem_els_p   (1024),
        .latency_p   (4)
    ) dut (
        .clk_i               (clk),
        .reset_i             (rst),
        .mem_cmd_header_i    (cmdHdr),
        .mem_cmd_data_i      (cmdData),
        .mem_cmd_v_i         (cmdV),
        .mem_cmd_ready_and_o (cmdReady),
        .mem_cmd_last_i      (cmdLast),
        .mem_resp_header_o   (respHdr),
        .mem_resp_data_o     (respData),
        .mem_resp_v_o        (respV),
        .mem_resp_ready_and_i(respReady),
        .mem_resp_last_o     (respLast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bp_bedrock_mem_header_s mkHdr(input bp_bedrock_mem_type_e t, input logic [39:0] a,
                                                     input bp_bedrock_msg_size_e s, input logic [15:0] p);
        bp_bedrock_mem_header_s h;
        h.msg_type = t;
        h.addr     = a;
        h.size     = s;
        h.payload  = p;
        return h;
    endfunction

    task automatic checkVal(input string name, input logic [127:0] got, input logic [127:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pushExp(input bp_bedrock_mem_header_s h, input logic [63:0] d, input logic l);
        expBeat_t e;
        e.hdr  = h;
        e.data = d;
        e.last = l;
        expQ.push_back(e);
    endtask

    // Monitor: every presented beat must match the head of the scoreboard.
    task automatic checkOutput();
        expBeat_t e;
        if (!rst && respV) begin
            checkVal("cmdReadyDuringResp", 128'(cmdReady), 128'(0));
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedBeat: got hdr %h data %h last %b expected none", respHdr, respData, respLast);
            end else begin
                e = expQ[0];
                checkVal("respBeat", {respHdr, respData, respLast}, {e.hdr, e.data, e.last});
                if (respReady) void'(expQ.pop_front());
            end
        end
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        respReady = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            respReady = (readyMode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendBeat(input bp_bedrock_mem_header_s h, input logic [63:0] d, input logic l);
        int n;
        cmdHdr  = h;
        cmdData = d;
        cmdLast = l;
        cmdV    = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmdReady) break;
            n++;
            if (n > 200) begin
                checkVal("cmdAcceptTimeout", 128'(0), 128'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        cmdV    = 1'b0;
        cmdLast = 1'b0;
    endtask

    task automatic applyStimulus(input bp_bedrock_mem_header_s h, input logic [63:0] beats [8], input int n);
        for (int k = 0; k < n; k++) sendBeat(h, beats[k], (k == n - 1));
    endtask

    // Edges from the accepting edge until the first response beat is valid.
    task automatic checkLatency(input string name, input int expEdges);
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (respV || n > 50) break;
        end
        checkVal(name, 128'(n), 128'(expEdges));
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (expQ.size() == 0 && !respV) break;
            n++;
            if (n > budget) begin
                checkVal("drainTimeout", 128'(expQ.size()), 128'(0));
                expQ.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] beats [8];
        logic [63:0] zeros [8];
        bp_bedrock_mem_header_s h;
        int n;

        for (int k = 0; k < 8; k++) zeros[k] = '0;
        rst     = 1'b1;
        cmdV    = 1'b0;
        cmdLast = 1'b0;
        cmdData = '0;
        cmdHdr  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("resetOutputs", {respV, cmdReady, respLast, respData, respHdr}, 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkVal("readyAfterReset", 128'(cmdReady), 128'(1));

        // Preload words 0..7 with their own index.
        h = mkHdr(e_bedrock_mem_wr, 40'h80000000, e_bedrock_msg_size_64, 16'h0011);
        for (int k = 0; k < 8; k++) beats[k] = 64'(k);
        pushExp(h, '0, 1'b1);
        applyStimulus(h, beats, 8);
        waitDrain(200);

        // Aligned 64B read: words 0..7 in order, latency 4.
        h = mkHdr(e_bedrock_mem_rd, 40'h80000000, e_bedrock_msg_size_64, 16'h0022);
        for (int k = 0; k < 8; k++) pushExp(h, 64'(k), (k == 7));
        applyStimulus(h, zeros, 1);
        checkLatency("readLatency", 4);
        waitDrain(200);

        // Critical-word-first read starting at word 3.
        h = mkHdr(e_bedrock_mem_rd, 40'h80000018, e_bedrock_msg_size_64, 16'h0033);
        for (int k = 0; k < 8; k++) pushExp(h, 64'((3 + k) % 8), (k == 7));
        applyStimulus(h, zeros, 1);
        checkLatency("wrapLatency", 4);
        waitDrain(200);

        // Multi-beat write then read back.
        h = mkHdr(e_bedrock_mem_wr, 40'h40, e_bedrock_msg_size_64, 16'h0044);
        for (int k = 0; k < 8; k++) beats[k] = 64'hA0 + 64'(k);
        pushExp(h, '0, 1'b1);
        applyStimulus(h, beats, 8);
        waitDrain(200);
        h = mkHdr(e_bedrock_mem_rd, 40'h40, e_bedrock_msg_size_64, 16'h0055);
        for (int k = 0; k < 8; k++) pushExp(h, 64'hA0 + 64'(k), (k == 7));
        applyStimulus(h, zeros, 1);
        waitDrain(200);

        // Partial byte write inside an 8B word.
        h = mkHdr(e_bedrock_mem_uc_wr, 40'h100, e_bedrock_msg_size_8, 16'h0066);
        beats[0] = 64'h1122334455667788;
        pushExp(h, '0, 1'b1);
        applyStimulus(h, beats, 1);
        waitDrain(200);
        h = mkHdr(e_bedrock_mem_uc_wr, 40'h106, e_bedrock_msg_size_2, 16'h0077);
        beats[0] = 64'hBEEF_BEEF_BEEF_BEEF;
        pushExp(h, '0, 1'b1);
        applyStimulus(h, beats, 1);
        waitDrain(200);
        h = mkHdr(e_bedrock_mem_uc_rd, 40'h100, e_bedrock_msg_size_8, 16'h0088);
        pushExp(h, 64'hBEEF_3344_5566_7788, 1'b1);
        applyStimulus(h, zeros, 1);
        waitDrain(200);

        // Sub-beat read replicates the 2B field across the beat.
        h = mkHdr(e_bedrock_mem_uc_rd, 40'h106, e_bedrock_msg_size_2, 16'h0099);
        pushExp(h, 64'hBEEF_BEEF_BEEF_BEEF, 1'b1);
        applyStimulus(h, zeros, 1);
        waitDrain(200);

        // Unsupported type: one-beat response and the array stays untouched.
        h = mkHdr(e_bedrock_mem_amo, 40'h100, e_bedrock_msg_size_8, 16'h00AA);
        beats[0] = 64'hDEAD_DEAD_DEAD_DEAD;
        pushExp(h, '0, 1'b1);
        applyStimulus(h, beats, 1);
        waitDrain(200);
        h = mkHdr(e_bedrock_mem_uc_rd, 40'h100, e_bedrock_msg_size_8, 16'h00BB);
        pushExp(h, 64'hBEEF_3344_5566_7788, 1'b1);
        applyStimulus(h, zeros, 1);
        waitDrain(200);

        // Random back-pressure on a wrapped read.
        readyMode = 1;
        h = mkHdr(e_bedrock_mem_rd, 40'h80000018, e_bedrock_msg_size_64, 16'h00CC);
        for (int k = 0; k < 8; k++) pushExp(h, 64'((3 + k) % 8), (k == 7));
        applyStimulus(h, zeros, 1);
        waitDrain(1000);
        readyMode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while beat 3 is being presented.
        h = mkHdr(e_bedrock_mem_rd, 40'h80000000, e_bedrock_msg_size_64, 16'h00DD);
        for (int k = 0; k < 8; k++) pushExp(h, 64'(k), (k == 7));
        applyStimulus(h, zeros, 1);
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (expQ.size() == 5) break;
            n++;
            if (n > 200) begin
                checkVal("beat3Timeout", 128'(expQ.size()), 128'(5));
                break;
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        expQ.delete();
        #1;
        checkVal("resetMidResp", {respV, cmdReady, respLast, respData, respHdr}, 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkVal("idleAfterReset", {respV, cmdReady}, 128'(1));

        // Normal read after the abandoned transaction; array survived reset.
        h = mkHdr(e_bedrock_mem_rd, 40'h40, e_bedrock_msg_size_64, 16'h00EE);
        for (int k = 0; k < 8; k++) pushExp(h, 64'hA0 + 64'(k), (k == 7));
        applyStimulus(h, zeros, 1);
        checkLatency("postResetLatency", 4);
        waitDrain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
